hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Iterative multiply/divide unit beside the combinational ALU in the execute stage. It produces the full 2*WORD_LENGTH product, or the quotient and remainder, into HI/LO registers, which the ALU operand path then reads. It takes the same dataA/dataB operands as the ALU. It covers what the ALU cannot do: full-width products and division.

Parameters:
WORD_LENGTH, 32, operand width; HI and LO are each WORD_LENGTH bits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op  input  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
dataA  input  WORD_LENGTH  multiplicand / dividend / move source
dataB  input  WORD_LENGTH  multiplier / divisor
busy  output  1  high while an operation is in progress (MUL, DIV, DONE)
done  output  1  one-cycle pulse; HI/LO are valid in this cycle
div_by_zero  output  1  sticky flag for the last DIVU; cleared by the next accepted start
hi  output  WORD_LENGTH  HI register
lo  output  WORD_LENGTH  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; iteration counter=0.
  - Reset wins over every other input in the same cycle.
  - Reset mid-operation aborts the operation; HI/LO go to 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 with op=00 latches operands and goes to MUL.
  - start=1 with op=01 latches operands and goes to DIV.
  - start=1 with op=10 writes hi<=dataA and goes to DONE.
  - start=1 with op=11 writes lo<=dataA and goes to DONE.
- start outside IDLE is ignored; it is not queued.
- Operands are captured at the accepting edge. Later changes on dataA/dataB do not affect the operation.
- MUL, shift-add:
  - Uses a 2*WORD_LENGTH accumulator.
  - Exactly WORD_LENGTH iterations, counter 0..WORD_LENGTH-1, one multiplier bit per cycle, LSB first.
  - On the final iteration, {hi,lo} <= full product and state goes to DONE.
- DIV, restoring division:
  - WORD_LENGTH iterations; each shifts the remainder left and conditionally subtracts the divisor.
  - Result: lo=quotient, hi=remainder, then DONE.
- Divide by zero: if dataB==0 at acceptance, DIV is skipped.
  - The unit goes straight to DONE with lo=all ones and hi=dataA, and sets div_by_zero=1.
- DONE: done=1 for exactly one cycle, then return to IDLE. busy is high in DONE.
- Latency, counting from the accepting edge E:
  - MULTU/DIVU: done is high in the cycle after edge E+WORD_LENGTH.
  - MTHI/MTLO and divide-by-zero: done is high in the cycle after edge E.
- A new start may be accepted on the edge that leaves DONE only if the state is already IDLE. A start asserted in DONE is ignored.
- HI/LO hold their value between operations. During MUL/DIV, hi/lo keep the previous result; internal accumulators are separate.
- Arithmetic is unsigned modulo 2^(2*WORD_LENGTH). Intermediate subtraction uses WORD_LENGTH+1 bits, so the borrow can be detected.

Optional Feature:
Macro SIGNED_MULDIV_EN.
- When defined, adds input port signed_op (1 bit), sampled with start.
  - With signed_op=1, operands are converted to magnitudes at acceptance.
  - The product sign is set to sign(A) XOR sign(B).
  - The quotient sign is sign(A) XOR sign(B); the remainder takes the sign of the dividend.
  - The sign fix-up is applied on the final iteration, so latency is unchanged.
  - Signed divide by zero gives the same result as unsigned: lo=all ones, hi=dataA.
- When not defined, the signed_op port does not exist and every operation is unsigned.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> hi=0, lo=0, busy=0, done=0, div_by_zero=0.
- MULTU: dataA=0xFFFFFFFF, dataB=0xFFFFFFFF, start -> busy for 33 cycles (32 iterations plus DONE), done one cycle, hi=0xFFFFFFFE, lo=0x00000001.
- DIVU: dataA=100, dataB=7 -> after 32 iterations, done with lo=14, hi=2, div_by_zero=0.
- Divide by zero: dataA=0x1234, dataB=0 -> done on the second cycle, lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1. The next accepted start clears the flag.
- Ignored start and mid-op reset: start DIVU, then pulse start with op=10 at iteration 5 -> the pulse is ignored and the result is correct. Repeat with reset at iteration 10 -> IDLE next cycle, hi=lo=0, no done pulse.
- MTHI/MTLO then SIGNED_MULDIV_EN: MTHI with dataA=0xAA, then MTLO with dataA=0x55 -> hi=0xAA, lo=0x55, each done one cycle after acceptance. With the macro defined and signed_op=1, dataA=-6, dataB=4 -> hi=0xFFFFFFFF, lo=0xFFFFFFE8. DIV of -7 by 2 -> lo=-3, hi=-1.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative shift-add multiplier and restoring divider
// writing a full-width product or quotient/remainder into HI/LO.
// Optional signed operation is enabled by defining SIGNED_MULDIV_EN.
module hilo_muldiv_unit #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [WORD_LENGTH-1:0] dataA,
  input  logic [WORD_LENGTH-1:0] dataB,
`ifdef SIGNED_MULDIV_EN
  input  logic                   signed_op,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   div_by_zero,
  output logic [WORD_LENGTH-1:0] hi,
  output logic [WORD_LENGTH-1:0] lo
);

  localparam int W     = WORD_LENGTH;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_acc;     // product accumulator
  logic [2*W-1:0]   r_mcand;   // multiplicand, shifted left each step
  logic [W-1:0]     r_opb;     // multiplier (shifted right) or divisor (held)
  logic [W-1:0]     r_rem;     // partial remainder
  logic [W-1:0]     r_quo;     // dividend bits shift out, quotient bits shift in
  logic             r_neg_x;   // result sign: sign(A) xor sign(B)
  logic             r_neg_a;   // remainder sign follows the dividend
  logic [W-1:0]     r_hi, r_lo;
  logic             r_dz;

  logic             w_signed;
`ifdef SIGNED_MULDIV_EN
  assign w_signed = signed_op;
`else
  assign w_signed = 1'b0;
`endif

  // Signed operands are converted to magnitudes when accepted
  logic [W-1:0] w_mag_a, w_mag_b;
  logic         w_neg_a_in, w_neg_b_in;
  assign w_neg_a_in = w_signed & dataA[W-1];
  assign w_neg_b_in = w_signed & dataB[W-1];
  assign w_mag_a    = w_neg_a_in ? -dataA : dataA;
  assign w_mag_b    = w_neg_b_in ? -dataB : dataB;

  logic w_last;
  assign w_last = (r_cnt == LAST);

  // Multiply step: add the shifted multiplicand when the current multiplier bit is set
  logic [2*W-1:0] w_acc_sum, w_prod_fix;
  assign w_acc_sum  = r_acc + (r_opb[0] ? r_mcand : {(2*W){1'b0}});
  assign w_prod_fix = r_neg_x ? -w_acc_sum : w_acc_sum;

  // Divide step: W+1-bit trial subtraction, the top bit of the difference is the borrow
  logic [W:0]   w_shift, w_diff;
  logic         w_borrow;
  logic [W-1:0] w_rem_next, w_quo_next, w_rem_fix, w_quo_fix;
  assign w_shift    = {r_rem, r_quo[W-1]};
  assign w_diff     = w_shift - {1'b0, r_opb};
  assign w_borrow   = w_diff[W];
  assign w_rem_next = w_borrow ? w_shift[W-1:0] : w_diff[W-1:0];
  assign w_quo_next = {r_quo[W-2:0], ~w_borrow};
  assign w_rem_fix  = r_neg_a ? -w_rem_next : w_rem_next;
  assign w_quo_fix  = r_neg_x ? -w_quo_next : w_quo_next;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULTU: w_state_next = S_MUL;
            OP_DIVU:  w_state_next = (dataB == '0) ? S_DONE : S_DIV;
            default:  w_state_next = S_DONE;
          endcase
        end
      end
      S_MUL:   if (w_last) w_state_next = S_DONE;
      S_DIV:   if (w_last) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Datapath: operand capture, iterations, and HI/LO result write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_opb   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_neg_x <= 1'b0;
      r_neg_a <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_dz    <= 1'b0;
            r_neg_x <= w_neg_a_in ^ w_neg_b_in;
            r_neg_a <= w_neg_a_in;
            case (op)
              OP_MULTU: begin
                r_acc   <= '0;
                r_mcand <= {{W{1'b0}}, w_mag_a};
                r_opb   <= w_mag_b;
              end
              OP_DIVU: begin
                if (dataB == '0) begin
                  r_hi <= dataA;
                  r_lo <= '1;
                  r_dz <= 1'b1;
                end else begin
                  r_rem <= '0;
                  r_quo <= w_mag_a;
                  r_opb <= w_mag_b;
                end
              end
              OP_MTHI: r_hi <= dataA;
              default: r_lo <= dataA;
            endcase
          end
        end
        S_MUL: begin
          r_acc   <= w_acc_sum;
          r_mcand <= r_mcand << 1;
          r_opb   <= r_opb >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) {r_hi, r_lo} <= w_prod_fix;
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: a result-level model predicts
// HI/LO/status every cycle; directed vectors add literal expectations.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start, signed_op;
  logic [1:0]    op;
  logic [W-1:0]  dataA, dataB;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WORD_LENGTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .dataA(dataA), .dataB(dataB),
`ifdef SIGNED_MULDIV_EN
    .signed_op(signed_op),
`endif
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_dz;
  int           m_rem;
  bit           m_done;
  bit           chk_en = 1'b0;
  int           n_done_seen = 0;

  function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint r;
    if (s) r = longint'($signed(a)) * longint'($signed(b));
    else   r = longint'({32'h0, a}) * longint'({32'h0, b});
    return r;
  endfunction

  // returns {remainder, quotient}
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint q, r;
    if (s) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'h0, a}) / longint'({32'h0, b});
      r = longint'({32'h0, a}) % longint'({32'h0, b});
    end
    return {r[31:0], q[31:0]};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_dz = 1'b0; m_rem = 0; m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
      end
    end else if (start) begin
      m_dz = 1'b0;
      case (op)
        2'b00: begin {p_hi, p_lo} = model_mul(dataA, dataB, signed_op); m_rem = W; end
        2'b01: begin
          if (dataB == 0) begin
            m_hi = dataA; m_lo = '1; m_dz = 1'b1; m_done = 1'b1;
          end else begin
            {p_hi, p_lo} = model_div(dataA, dataB, signed_op); m_rem = W;
          end
        end
        2'b10:   begin m_hi = dataA; m_done = 1'b1; end
        default: begin m_lo = dataA; m_done = 1'b1; end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, (m_rem > 0) || m_done);
      chk("done", done, m_done);
      chk("div_by_zero", div_by_zero, m_dz);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
    if (done === 1'b1) n_done_seen++;
  end

  // Issue one operation and wait (bounded) for done; ends at the done cycle
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit s, output int lat);
    @(negedge clk);
    op = o; dataA = a; dataB = b; signed_op = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dataA = ~a; dataB = ~b;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) chk("done_timeout", done, 1'b1);
    $display("op=%0d a=0x%08h b=0x%08h s=%0d -> hi=0x%08h lo=0x%08h dz=%0d lat=%0d",
             o, a, b, s, hi, lo, div_by_zero, lat);
  endtask

  int lat, seen;

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; dataA = '0; dataB = '0; signed_op = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // full-width product
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat);
    chk("mul_lat", lat, 33);
    chk("mul_hi", hi, 32'hFFFFFFFE);
    chk("mul_lo", lo, 32'h00000001);

    // division
    run_op(2'b01, 32'd100, 32'd7, 1'b0, lat);
    chk("div_lat", lat, 33);
    chk("div_lo", lo, 14);
    chk("div_hi", hi, 2);
    chk("div_dz", div_by_zero, 0);

    // divide by zero, sticky flag, cleared by next accepted start
    run_op(2'b01, 32'h1234, 32'h0, 1'b0, lat);
    chk("dz_lat", lat, 1);
    chk("dz_lo", lo, 32'hFFFFFFFF);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_flag", div_by_zero, 1);
    repeat (3) @(negedge clk);
    chk("dz_sticky", div_by_zero, 1);

    // moves
    run_op(2'b10, 32'hAA, 32'h0, 1'b0, lat);
    chk("mthi_lat", lat, 1);
    chk("mthi_hi", hi, 32'hAA);
    chk("dz_cleared", div_by_zero, 0);
    run_op(2'b11, 32'h55, 32'h0, 1'b0, lat);
    chk("mtlo_lat", lat, 1);
    chk("mtlo_lo", lo, 32'h55);
    chk("mtlo_hi", hi, 32'hAA);

    // start during an operation is ignored
    @(negedge clk);
    op = 2'b01; dataA = 32'd100; dataB = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 2'b10; dataA = 32'hDEAD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    chk("ign_done", done, 1);
    chk("ign_lo", lo, 14);
    chk("ign_hi", hi, 2);
    $display("ignored-start DIVU -> hi=0x%08h lo=0x%08h", hi, lo);

    // start held into DONE is ignored
    @(negedge clk);
    op = 2'b11; dataA = 32'h77; start = 1'b1;
    @(negedge clk);
    chk("hold_done", done, 1);
    op = 2'b10; dataA = 32'h99;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("hold_hi", hi, 2);
    chk("hold_lo", lo, 32'h77);
    chk("hold_busy", busy, 0);
    $display("start-in-DONE -> hi=0x%08h lo=0x%08h", hi, lo);

    // reset mid-operation
    @(negedge clk);
    op = 2'b01; dataA = 32'd1000; dataB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    seen = n_done_seen;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_hi", hi, 0);
    chk("mrst_lo", lo, 0);
    chk("mrst_busy", busy, 0);
    repeat (40) @(negedge clk);
    chk("mrst_no_done", n_done_seen, seen);
    $display("mid-op reset -> hi=0x%08h lo=0x%08h busy=%0d", hi, lo, busy);

    // assorted vectors checked by the model
    run_op(2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b0, lat);
    run_op(2'b00, 32'h0, 32'h5, 1'b0, lat);
    chk("mul0_lo", lo, 0);
    run_op(2'b00, 32'h10000, 32'h10000, 1'b0, lat);
    chk("mul_2p32_hi", hi, 1);
    chk("mul_2p32_lo", lo, 0);
    run_op(2'b01, 32'hFFFFFFFF, 32'h1, 1'b0, lat);
    chk("div1_lo", lo, 32'hFFFFFFFF);
    chk("div1_hi", hi, 0);
    run_op(2'b01, 32'd5, 32'hFFFFFFFF, 1'b0, lat);
    chk("divbig_lo", lo, 0);
    chk("divbig_hi", hi, 5);
    run_op(2'b01, 32'h80000000, 32'd3, 1'b0, lat);
    chk("div3_lo", lo, 32'h2AAAAAAA);
    chk("div3_hi", hi, 2);

`ifdef SIGNED_MULDIV_EN
    run_op(2'b00, 32'hFFFFFFFA, 32'd4, 1'b1, lat);
    chk("smul_lat", lat, 33);
    chk("smul_hi", hi, 32'hFFFFFFFF);
    chk("smul_lo", lo, 32'hFFFFFFE8);
    run_op(2'b01, 32'hFFFFFFF9, 32'd2, 1'b1, lat);
    chk("sdiv_lo", lo, 32'hFFFFFFFD);
    chk("sdiv_hi", hi, 32'hFFFFFFFF);
    run_op(2'b01, 32'hFFFFFFFB, 32'h0, 1'b1, lat);
    chk("sdz_lo", lo, 32'hFFFFFFFF);
    chk("sdz_hi", hi, 32'hFFFFFFFB);
    chk("sdz_flag", div_by_zero, 1);
    run_op(2'b00, 32'hFFFFFFFD, 32'hFFFFFFF9, 1'b1, lat);
    chk("smul_pos_lo", lo, 32'd21);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
